// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions used by the IDU and by alu_pipe.
package alu_pkg;

  localparam int ALU_OP_W           = 5;
  localparam int ALU_OP_ILLEGAL_MIN = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_BEQ     = 5'd0,
    OP_BNE     = 5'd1,
    OP_BLT     = 5'd2,
    OP_BGE     = 5'd3,
    OP_BLTU    = 5'd4,
    OP_BGEU    = 5'd5,
    OP_ADD     = 5'd6,
    OP_SUB     = 5'd7,
    OP_SLL     = 5'd8,
    OP_SLT     = 5'd9,
    OP_SLTU    = 5'd10,
    OP_XOR     = 5'd11,
    OP_SRL     = 5'd12,
    OP_SRA     = 5'd13,
    OP_OR      = 5'd14,
    OP_AND     = 5'd15,
    OP_ILLEGAL = 5'd16
  } alu_op_e;

  typedef struct packed {
    logic overflow;
    logic con_met;
    logic zero;
    logic err;
  } alu_flags_t;

  function automatic logic op_is_illegal(input logic [ALU_OP_W-1:0] op);
    return op >= ALU_OP_W'(ALU_OP_ILLEGAL_MIN);
  endfunction

  function automatic logic op_is_branch(input logic [ALU_OP_W-1:0] op);
    return op <= OP_BGEU;
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational execute unit: result and flags for one decoded operation.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     dat1,
  input  logic [XLEN-1:0]     dat2,
  output logic [XLEN-1:0]     result,
  output alu_flags_t          flags
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  assign shamt = dat2[SH_W-1:0];
  assign sum   = dat1 + dat2;
  assign diff  = dat1 - dat2;
  assign lt_s  = $signed(dat1) < $signed(dat2);
  assign lt_u  = dat1 < dat2;
  assign eq    = dat1 == dat2;

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_BEQ:  flags.con_met = eq;
      OP_BNE:  flags.con_met = !eq;
      OP_BLT:  flags.con_met = lt_s;
      OP_BGE:  flags.con_met = !lt_s;
      OP_BLTU: flags.con_met = lt_u;
      OP_BGEU: flags.con_met = !lt_u;
      OP_ADD: begin
        result         = sum;
        flags.overflow = (dat1[XLEN-1] == dat2[XLEN-1]) && (sum[XLEN-1] != dat1[XLEN-1]);
      end
      OP_SUB: begin
        result         = diff;
        flags.overflow = (dat1[XLEN-1] != dat2[XLEN-1]) && (diff[XLEN-1] != dat1[XLEN-1]);
      end
      OP_SLL:  result = dat1 << shamt;
      OP_SLT: begin
        result        = {{(XLEN-1){1'b0}}, lt_s};
        flags.con_met = lt_s;
      end
      OP_SLTU: begin
        result        = {{(XLEN-1){1'b0}}, lt_u};
        flags.con_met = lt_u;
      end
      OP_XOR:  result = dat1 ^ dat2;
      OP_SRL:  result = dat1 >> shamt;
      OP_SRA:  result = $unsigned($signed(dat1) >>> shamt);
      OP_OR:   result = dat1 | dat2;
      OP_AND:  result = dat1 & dat2;
      default: flags.err = 1'b1;
    endcase
    // Zero flag only describes arithmetic/logic results, never branches or illegal codes.
    if (!op_is_branch(op) && !op_is_illegal(op)) begin
      flags.zero = (result == '0);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Optional sticky illegal-op trap enabled by defining ALU_PIPE_ERR_TRAP_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge, and ready never
// depends combinationally on valid of the same side.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                soc_clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [XLEN-1:0]     in_dat1,
  input  logic [XLEN-1:0]     in_dat2,
  input  logic [TAG_W-1:0]    in_tag,
`ifdef ALU_PIPE_ERR_TRAP_EN
  input  logic                err_clr,
  output logic                err_sticky,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_overflow,
  output logic                out_con_met,
  output logic                out_zero,
  output logic                out_err
);

  logic                s1_valid;
  logic [ALU_OP_W-1:0] s1_op;
  logic [XLEN-1:0]     s1_dat1;
  logic [XLEN-1:0]     s1_dat2;
  logic [TAG_W-1:0]    s1_tag;

  logic                s1_accept;
  logic                s2_can_load;
  logic                s2_load;
  logic                pipe_ready;

  logic [XLEN-1:0]     exec_result;
  alu_flags_t          exec_flags;

  assign s2_can_load = !out_valid || out_ready;
  assign s2_load     = s1_valid && s2_can_load;
  assign pipe_ready  = !s1_valid || s2_can_load;
  assign s1_accept   = in_valid && in_ready;

`ifdef ALU_PIPE_ERR_TRAP_EN
  logic trap_set;

  assign trap_set = s2_load && op_is_illegal(s1_op);
  // The trap only blocks new accepts; whatever already sits in S1 still drains.
  assign in_ready = pipe_ready && !err_sticky;

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      err_sticky <= 1'b0;
    end else if (trap_set) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`else
  assign in_ready = pipe_ready;
`endif

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_dat1  <= '0;
      s1_dat2  <= '0;
      s1_tag   <= '0;
    end else begin
      if (s1_accept) begin
        s1_valid <= 1'b1;
        s1_op    <= in_op;
        s1_dat1  <= in_dat1;
        s1_dat2  <= in_dat2;
        s1_tag   <= in_tag;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  alu_exec #(
    .XLEN(XLEN)
  ) u_exec (
    .op     (s1_op),
    .dat1   (s1_dat1),
    .dat2   (s1_dat2),
    .result (exec_result),
    .flags  (exec_flags)
  );

  // S2 payload only changes on a load, so it stays frozen under backpressure.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_tag      <= '0;
      out_overflow <= 1'b0;
      out_con_met  <= 1'b0;
      out_zero     <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid    <= 1'b1;
        out_result   <= exec_result;
        out_tag      <= s1_tag;
        out_overflow <= exec_flags.overflow;
        out_con_met  <= exec_flags.con_met;
        out_zero     <= exec_flags.zero;
        out_err      <= exec_flags.err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (32-bit instance plus a 16-bit shift check).
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int W     = XLEN + TAG_W + 4;
  localparam int W16   = 16 + TAG_W + 4;

  logic                soc_clk = 1'b0;
  logic                reset   = 1'b0;
  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] in_op;
  logic [XLEN-1:0]     in_dat1;
  logic [XLEN-1:0]     in_dat2;
  logic [TAG_W-1:0]    in_tag;
  logic                err_clr;
  logic                err_sticky;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic [TAG_W-1:0]    out_tag;
  logic                out_overflow, out_con_met, out_zero, out_err;

  logic                d16_in_valid, d16_in_ready;
  logic [ALU_OP_W-1:0] d16_in_op;
  logic [15:0]         d16_in_dat1, d16_in_dat2;
  logic [TAG_W-1:0]    d16_in_tag;
  logic                d16_err_clr, d16_err_sticky;
  logic                d16_out_valid, d16_out_ready;
  logic [15:0]         d16_out_result;
  logic [TAG_W-1:0]    d16_out_tag;
  logic                d16_ovf, d16_con, d16_zero, d16_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0]   exp_q[$];
  int             lat_q[$];
  logic [W16-1:0] exp16_q[$];

  // clock / reset block
  always #5 soc_clk = ~soc_clk;
  always @(posedge soc_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) u_dut (
    .soc_clk      (soc_clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_dat1      (in_dat1),
    .in_dat2      (in_dat2),
    .in_tag       (in_tag),
`ifdef ALU_PIPE_ERR_TRAP_EN
    .err_clr      (err_clr),
    .err_sticky   (err_sticky),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_overflow (out_overflow),
    .out_con_met  (out_con_met),
    .out_zero     (out_zero),
    .out_err      (out_err)
  );

  alu_pipe #(.XLEN(16), .TAG_W(TAG_W)) u_dut16 (
    .soc_clk      (soc_clk),
    .reset        (reset),
    .in_valid     (d16_in_valid),
    .in_ready     (d16_in_ready),
    .in_op        (d16_in_op),
    .in_dat1      (d16_in_dat1),
    .in_dat2      (d16_in_dat2),
    .in_tag       (d16_in_tag),
`ifdef ALU_PIPE_ERR_TRAP_EN
    .err_clr      (d16_err_clr),
    .err_sticky   (d16_err_sticky),
`endif
    .out_valid    (d16_out_valid),
    .out_ready    (d16_out_ready),
    .out_result   (d16_out_result),
    .out_tag      (d16_out_tag),
    .out_overflow (d16_ovf),
    .out_con_met  (d16_con),
    .out_zero     (d16_zero),
    .out_err      (d16_err)
  );

`ifndef ALU_PIPE_ERR_TRAP_EN
  initial begin
    err_sticky     = 1'b0;
    d16_err_sticky = 1'b0;
  end
`endif

  function automatic logic [W-1:0] mk(input logic [31:0] r, input logic [3:0] t,
                                      input logic ov, input logic cm, input logic z, input logic e);
    return {r, t, ov, cm, z, e};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // driver: present one op, wait for in_ready, record expectation before the accepting edge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input logic [W-1:0] e, input bit lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_dat1  = a;
    in_dat2  = b;
    in_tag   = t;
    #1;
    while (!in_ready && n < 40) begin
      @(posedge soc_clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout tag %0d: in_ready 0, required 1", t);
    end else begin
      exp_q.push_back(e);
      lat_q.push_back(lat ? cyc + 1 : -1);
    end
    @(posedge soc_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp16_q.size() != 0) && n < 60) begin
      @(posedge soc_clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(exp_q.size() + exp16_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge soc_clk) begin
    logic [W-1:0]   act;
    logic [W16-1:0] act16;
    logic [W-1:0]   e;
    int             l;
    if (reset && out_valid) begin
      act = {out_result, out_tag, out_overflow, out_con_met, out_zero, out_err};
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got 0x%0h, required no output", act);
      end else if (!out_ready) begin
        check("hold_stable", 64'(act), 64'(exp_q[0]));
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result", 64'(act), 64'(e));
        if (l >= 0) check("latency", 64'(cyc), 64'(l + 1));
      end
    end
    if (reset && d16_out_valid) begin
      act16 = {d16_out_result, d16_out_tag, d16_ovf, d16_con, d16_zero, d16_err};
      if (exp16_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output16: got 0x%0h, required no output", act16);
      end else begin
        check("result16", 64'(act16), 64'(exp16_q.pop_front()));
      end
    end
  end

  initial begin
    in_valid = 0; in_op = '0; in_dat1 = '0; in_dat2 = '0; in_tag = '0;
    err_clr = 0; out_ready = 1;
    d16_in_valid = 0; d16_in_op = '0; d16_in_dat1 = '0; d16_in_dat2 = '0; d16_in_tag = '0;
    d16_err_clr = 0; d16_out_ready = 1;

    repeat (3) @(posedge soc_clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'({out_overflow, out_con_met, out_zero, out_err}), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    @(negedge soc_clk);
    reset = 1'b1;
    @(posedge soc_clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // first op with latency check, then back-to-back stream
    issue(OP_ADD,  32'h7FFF_FFFF, 32'h1,        4'd3, mk(32'h8000_0000, 4'd3, 1, 0, 0, 0), 1);
    issue(OP_SUB,  32'd5,         32'd5,        4'd4, mk(32'h0,         4'd4, 0, 0, 1, 0), 1);
    issue(OP_SRA,  32'h8000_0000, 32'd4,        4'd5, mk(32'hF800_0000, 4'd5, 0, 0, 0, 0), 1);
    issue(OP_SLTU, 32'd1,         32'd2,        4'd6, mk(32'h1,         4'd6, 0, 1, 0, 0), 1);
    issue(OP_BLT,  32'hFFFF_FFFF, 32'd1,        4'd7, mk(32'h0,         4'd7, 0, 1, 0, 0), 0);
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1,        4'd8, mk(32'h0,         4'd8, 0, 0, 0, 0), 0);
    issue(OP_SUB,  32'h8000_0000, 32'd1,        4'd1, mk(32'h7FFF_FFFF, 4'd1, 1, 0, 0, 0), 0);
    issue(OP_ADD,  32'hFFFF_FFFF, 32'd1,        4'd2, mk(32'h0,         4'd2, 0, 0, 1, 0), 0);
    issue(OP_SRL,  32'h8000_0000, 32'h24,       4'd9, mk(32'h0800_0000, 4'd9, 0, 0, 0, 0), 0);
    issue(OP_SLL,  32'h1,         32'd31,       4'd10, mk(32'h8000_0000, 4'd10, 0, 0, 0, 0), 0);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd0,        4'd11, mk(32'h1,        4'd11, 0, 1, 0, 0), 0);
    issue(OP_BEQ,  32'd7,         32'd7,        4'd12, mk(32'h0,        4'd12, 0, 1, 0, 0), 0);
    issue(OP_BNE,  32'd7,         32'd7,        4'd13, mk(32'h0,        4'd13, 0, 0, 0, 0), 0);
    issue(OP_BGE,  32'h8000_0000, 32'd0,        4'd14, mk(32'h0,        4'd14, 0, 0, 0, 0), 0);
    issue(OP_BGEU, 32'd5,         32'd5,        4'd15, mk(32'h0,        4'd15, 0, 1, 0, 0), 0);
    wait_drain();

    // backpressure: two ops buffer, third stalls until out_ready returns
    out_ready = 1'b0;
    issue(OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 4'd9,  mk(32'hF0F0_0F0F, 4'd9,  0, 0, 0, 0), 0);
    issue(OP_AND, 32'hFFFF_0000, 32'h1234_5678, 4'd10, mk(32'h1234_0000, 4'd10, 0, 0, 0, 0), 0);
    fork
      issue(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 4'd11, mk(32'h5555_5555, 4'd11, 0, 0, 0, 0), 0);
      begin
        repeat (4) @(posedge soc_clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // illegal opcode
    issue(5'd20, 32'h1234, 32'h5678, 4'd12, mk(32'h0, 4'd12, 0, 0, 0, 1), 0);
`ifdef ALU_PIPE_ERR_TRAP_EN
    repeat (3) @(posedge soc_clk);
    #1;
    check("trap_sticky", 64'(err_sticky), 64'd1);
    check("trap_in_ready", 64'(in_ready), 64'd0);
    err_clr = 1'b1;
    @(posedge soc_clk);
    #1;
    err_clr = 1'b0;
    check("trap_cleared", 64'(err_sticky), 64'd0);
    check("trap_clr_ready", 64'(in_ready), 64'd1);
`else
    check("illegal_in_ready", 64'(in_ready), 64'd1);
`endif
    issue(OP_ADD, 32'd2, 32'd3, 4'd13, mk(32'h5, 4'd13, 0, 0, 0, 0), 1);
    issue(5'd16,  32'd1, 32'd1, 4'd14, mk(32'h0, 4'd14, 0, 0, 0, 1), 0);
    wait_drain();
`ifdef ALU_PIPE_ERR_TRAP_EN
    err_clr = 1'b1;
    @(posedge soc_clk);
    #1;
    err_clr = 1'b0;
`endif

    // reset with ops in flight discards them
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 4'd1, mk(32'h2, 4'd1, 0, 0, 0, 0), 0);
    issue(OP_ADD, 32'd2, 32'd2, 4'd2, mk(32'h4, 4'd2, 0, 0, 0, 0), 0);
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge soc_clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge soc_clk);
    #1;
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    check("postrst_in_ready", 64'(in_ready), 64'd1);

    // 16-bit instance: shift amount uses only the low 4 bits
    d16_in_valid = 1'b1;
    d16_in_op    = OP_SLL;
    d16_in_dat1  = 16'h0001;
    d16_in_dat2  = 16'h0013;
    d16_in_tag   = 4'd5;
    #1;
    check("d16_in_ready", 64'(d16_in_ready), 64'd1);
    exp16_q.push_back({16'h0008, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge soc_clk);
    #1;
    d16_in_valid = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
